// File: rtl/transmissor_pkg.sv
// Shared types, symbol code table and sizing for the symbol-sequence transmitter.
package transmissor_pkg;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned SYM_W   = 7;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SEQ_W   = MAX_LEN * IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SEND,
        GAP,
        DONE
    } state_t;

    function automatic logic [SYM_W-1:0] sym_code(input logic [IDX_W-1:0] idx);
        logic [SYM_W-1:0] code;
        case (idx)
            3'd0:    code = 7'h58;
            3'd1:    code = 7'h6B;
            3'd2:    code = 7'h4F;
            3'd3:    code = 7'h28;
            3'd4:    code = 7'h0C;
            3'd5:    code = 7'h32;
            3'd6:    code = 7'h16;
            default: code = 7'h23;
        endcase
        return code;
    endfunction

    // Indices 5..7 end a sequence after being sent.
    function automatic logic is_terminal(input logic [IDX_W-1:0] idx);
        return (idx >= 3'd5);
    endfunction

endpackage

// File: rtl/transmissor_sequencia_if.sv
// Symbol bus between the transmitter (master) and the sequence checker (slave).
interface transmissor_sequencia_if;
    import transmissor_pkg::*;

    logic [SYM_W-1:0] tx_sym;
    logic             tx_strobe;
    logic             rx_reset;

    modport master (output tx_sym, output tx_strobe, output rx_reset);
    modport slave  (input  tx_sym, input  tx_strobe, input  rx_reset);
endinterface

// File: rtl/sincroniza_reset.sv
// Two-flop reset conditioner: asserts asynchronously, releases on the clock.
module sincroniza_reset (
    input  logic clk,
    input  logic reset_n,
    output logic rst_n_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_n_sync = sync_q;

endmodule

// File: rtl/transmissor_sequencia.sv
// Sends a loaded program of up to eight symbols to the checker, one strobe per
// symbol separated by GAP_CYCLES idle cycles, preceded by a checker clear pulse.
module transmissor_sequencia
    import transmissor_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     seq_len,
    input  logic [SEQ_W-1:0]     seq_idx,
    transmissor_sequencia_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 truncated,
    output logic [CNT_W-1:0]     sent_count
);

    localparam int unsigned GAP_W = 4;

    logic rst_n_sync;

    sincroniza_reset u_sincroniza_reset (
        .clk        (clk),
        .reset_n    (reset_n),
        .rst_n_sync (rst_n_sync)
    );

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             strobe_q, strobe_d;
    logic             rxr_q, rxr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             trunc_q, trunc_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] len_clamp_c;
    logic [IDX_W-1:0] cur_idx_c;

    assign len_clamp_c = (seq_len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : seq_len;
    // The program is consumed as a shift register; the current index is at the bottom.
    assign cur_idx_c   = idx_q[IDX_W-1:0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        gap_d    = gap_q;
        sym_d    = sym_q;
        strobe_d = 1'b0;
        rxr_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        trunc_d  = trunc_q;
        sent_d   = sent_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d  = seq_idx;
                    len_d  = len_clamp_c;
                    sent_d = '0;
                    busy_d = 1'b1;
                    if ((len_clamp_c == '0) || abort) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        trunc_d = (len_clamp_c != '0);
                    end else begin
                        state_d = CLEAR;
                        rxr_d   = 1'b1;
                        trunc_d = 1'b0;
                    end
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    trunc_d = 1'b1;
                end else begin
                    state_d  = SEND;
                    strobe_d = 1'b1;
                    sym_d    = sym_code(cur_idx_c);
                    sent_d   = sent_q + CNT_W'(1);
                end
            end
            SEND: begin
                if (is_terminal(cur_idx_c) || (sent_q == len_q) || abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    trunc_d = (sent_q < len_q);
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                    idx_d   = idx_q >> IDX_W;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    trunc_d = (sent_q < len_q);
                end else if (gap_q == '0) begin
                    state_d  = SEND;
                    strobe_d = 1'b1;
                    sym_d    = sym_code(cur_idx_c);
                    sent_d   = sent_q + CNT_W'(1);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            sym_q    <= '0;
            strobe_q <= 1'b0;
            rxr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            trunc_q  <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            sym_q    <= sym_d;
            strobe_q <= strobe_d;
            rxr_q    <= rxr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            trunc_q  <= trunc_d;
            sent_q   <= sent_d;
        end
    end

    assign bus.tx_sym    = sym_q;
    assign bus.tx_strobe = strobe_q;
    assign bus.rx_reset  = rxr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign truncated     = trunc_q;
    assign sent_count    = sent_q;

endmodule

// File: tb/tb_transmissor_sequencia.sv
// Directed bench for transmissor_sequencia with hand-computed strobe timing and codes.
module tb_transmissor_sequencia;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [3:0]  seq_len;
    logic [23:0] seq_idx;
    logic        busy;
    logic        done;
    logic        truncated;
    logic [3:0]  sent_count;

    transmissor_sequencia_if bus_if ();

    transmissor_sequencia #(.GAP_CYCLES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .seq_len    (seq_len),
        .seq_idx    (seq_idx),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .truncated  (truncated),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         st_cyc[$];
    logic [6:0] st_code[$];
    int         rxr_cyc;
    int         done_cyc;
    int         done_n;
    logic       done_trunc;
    logic [3:0] done_sent;
    logic [6:0] exp_code[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the next edge (k), j counts cycles after it.
    task automatic run_seq(input logic [3:0] len, input logic [23:0] idx,
                           input int abort_at, input int restart_at);
        st_cyc.delete();
        st_code.delete();
        rxr_cyc    = -1;
        done_cyc   = -1;
        done_n     = 0;
        done_trunc = 1'bx;
        done_sent  = 4'hx;
        seq_len    = len;
        seq_idx    = idx;
        start      = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (bus_if.tx_strobe) begin
                st_cyc.push_back(j);
                st_code.push_back(bus_if.tx_sym);
            end
            if (bus_if.rx_reset && rxr_cyc < 0) rxr_cyc = j;
            if (done) begin
                done_n++;
                done_cyc   = j;
                done_trunc = truncated;
                done_sent  = sent_count;
            end
            start = (j == restart_at);
            abort = (j == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic expect_seq(input string tag, input int exp_rxr, input int n,
                              input int exp_done, input logic exp_trunc, input logic [3:0] exp_sent);
        check({tag, "_rxr_cyc"}, 32'(rxr_cyc), 32'(exp_rxr));
        check({tag, "_nstrobe"}, 32'(st_cyc.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i),
                  (i < st_cyc.size()) ? 32'(st_cyc[i]) : 32'hFFFF_FFFF, 32'(2 + 3 * i));
            check($sformatf("%s_code%0d", tag, i),
                  (i < st_code.size()) ? 32'(st_code[i]) : 32'h0, 32'(exp_code[i]));
        end
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
        check({tag, "_done_n"}, 32'(done_n), 32'd1);
        check({tag, "_trunc"}, 32'(done_trunc), 32'(exp_trunc));
        check({tag, "_sent"}, 32'(done_sent), 32'(exp_sent));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    int late_done;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        seq_len = '0;
        seq_idx = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({bus_if.tx_sym, bus_if.tx_strobe, bus_if.rx_reset,
                                 busy, done, truncated, sent_count}), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // {0,1,5}: terminal on last symbol
        exp_code = '{7'h58, 7'h6B, 7'h32, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0};
        run_seq(4'd3, 24'h000148, -1, -1);
        expect_seq("t1", 1, 3, 9, 1'b0, 4'd3);
        check("t1_sym_hold", 32'(bus_if.tx_sym), 32'h32);

        // {3,7,0,1}: terminal 7 stops after two
        exp_code = '{7'h28, 7'h23, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0};
        run_seq(4'd4, 24'h00023B, -1, -1);
        expect_seq("t2", 1, 2, 6, 1'b1, 4'd2);

        // Zero length: done right away, no clear
        exp_code = '{7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0};
        run_seq(4'd0, 24'h000148, -1, -1);
        expect_seq("t3", -1, 0, 1, 1'b0, 4'd0);

        // Abort in first gap cycle after second strobe
        exp_code = '{7'h4F, 7'h28, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0};
        run_seq(4'd5, 24'h00471A, 6, -1);
        expect_seq("t4", 1, 2, 7, 1'b1, 4'd2);

        // Length 12 clamps to 8; mid-sequence start ignored
        exp_code = '{7'h58, 7'h6B, 7'h4F, 7'h28, 7'h0C, 7'h58, 7'h6B, 7'h4F};
        run_seq(4'd12, 24'h444688, -1, 10);
        expect_seq("t5", 1, 8, 24, 1'b0, 4'd8);

        // Abort during CLEAR: clear pulse completes, nothing sent
        exp_code = '{7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0};
        run_seq(4'd3, 24'h000148, 1, -1);
        expect_seq("t6", 1, 0, 2, 1'b1, 4'd0);

        // Reset during the first SEND cycle
        seq_len = 4'd3;
        seq_idx = 24'h000148;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t7_pre_strobe", 32'(bus_if.tx_strobe), 32'd1);
        #1 reset_n = 1'b0;
        #1 check("t7_async_clear", 32'({bus_if.tx_sym, bus_if.tx_strobe, bus_if.rx_reset,
                                         busy, done, truncated, sent_count}), 32'd0);
        late_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || bus_if.tx_strobe) late_done++;
        end
        check("t7_no_done", 32'(late_done), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_code = '{7'h58, 7'h6B, 7'h32, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0};
        run_seq(4'd3, 24'h000148, -1, -1);
        expect_seq("t8", 1, 3, 9, 1'b0, 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
